// File: rtl/chromosome_loader_if.sv
// Handshake and configuration-bus bundle between the GA controller and the chromosome loader.
// The controller side drives the serial stream; the loader side drives status and the LE buses.
interface chromosome_loader_if #(
  parameter int N_LE = 16
);
  logic                 start;
  logic                 ser_in;
  logic                 ser_valid;
  logic                 ser_ready;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 cfg_valid;
  logic [3*N_LE-1:0]    conf_func_bus;
  logic [12*N_LE-1:0]   conf_ins_bus;

  modport master (
    output start, ser_in, ser_valid,
    input  ser_ready, busy, done, err, cfg_valid, conf_func_bus, conf_ins_bus
  );

  modport slave (
    input  start, ser_in, ser_valid,
    output ser_ready, busy, done, err, cfg_valid, conf_func_bus, conf_ins_bus
  );
endinterface

// File: rtl/chromosome_loader.sv
// Bit-serial chromosome loader: assembles 15-bit genes into a shadow store, validates input
// indices, and atomically commits the whole configuration to the logic-element buses.
module chromosome_loader #(
  parameter int N_LE = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  chromosome_loader_if.slave bus
);
  localparam int         LW       = $clog2(N_LE + 1);
  localparam logic [5:0] MAX_IDX  = 6'd34;
  localparam logic [3:0] LAST_BIT = 4'd14;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [3:0]           bit_cnt;
  logic [LW-1:0]        le_cnt;
  logic                 err_acc;
  logic [13:0]          gene_sr;
  logic [3*N_LE-1:0]    shadow_func;
  logic [12*N_LE-1:0]   shadow_ins;

  logic                 accept;
  logic                 gene_end;
  logic                 last_gene;
  logic                 idx_bad;
  logic [14:0]          gene;
  logic [31:0]          slot;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can leave one
    // unassigned and infer a latch.
    state_nx  = state;
    accept    = (state == SHIFT) && bus.ser_valid;
    gene      = {gene_sr, bus.ser_in};
    gene_end  = accept && (bit_cnt == LAST_BIT);
    last_gene = (le_cnt == LW'(N_LE - 1));
    idx_bad   = (gene[5:0] > MAX_IDX) || (gene[11:6] > MAX_IDX);
    slot      = 32'(le_cnt);

    unique case (state)
      IDLE:    if (bus.start) state_nx = SHIFT;
      SHIFT:   if (gene_end && last_gene) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  assign bus.ser_ready = (state == SHIFT);
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt           <= '0;
      le_cnt            <= '0;
      err_acc           <= 1'b0;
      gene_sr           <= '0;
      // NOTE: the shadow store is flop-based and must read as all-zero after reset,
      // so it is cleared here rather than left to an uninitialised RAM.
      shadow_func       <= '0;
      shadow_ins        <= '0;
      bus.done          <= 1'b0;
      bus.err           <= 1'b0;
      bus.cfg_valid     <= 1'b0;
      bus.conf_func_bus <= '0;
      bus.conf_ins_bus  <= '0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.start) begin
            bit_cnt <= '0;
            le_cnt  <= '0;
            err_acc <= 1'b0;
          end
        end

        SHIFT: begin
          if (accept) begin
            gene_sr <= gene[13:0];
            if (gene_end) begin
              bit_cnt                  <= '0;
              le_cnt                   <= le_cnt + LW'(1);
              shadow_func[3*slot +: 3]   <= gene[14:12];
              shadow_ins[12*slot +: 12]  <= gene[11:0];
              if (idx_bad) err_acc <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end

        COMMIT: begin
          bus.done <= 1'b1;
          bus.err  <= err_acc;
          // A rejected chromosome never reaches the logic elements.
          if (!err_acc) begin
            bus.conf_func_bus <= shadow_func;
            bus.conf_ins_bus  <= shadow_ins;
            bus.cfg_valid     <= 1'b1;
          end
        end

        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_chromosome_loader.sv
// Self-checking bench for chromosome_loader (N_LE=2): a chromosome-level model predicts every
// output each cycle, and directed loads pin the model with hand-computed bus values.
module tb_chromosome_loader;
  localparam int N    = 2;
  localparam int BITS = 15 * N;

  logic clk = 1'b0;
  logic rst_n;

  chromosome_loader_if #(.N_LE(N)) bus ();
  chromosome_loader #(.N_LE(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [14:0] gene(input logic [2:0] f, input logic [5:0] a,
                                       input logic [5:0] b);
    return {f, b, a};
  endfunction

  // Chromosome-level model: collect the whole bit stream, decode it once complete.
  bit          chk_en = 1'b0;
  bit          m_active, m_commit, m_err, m_done, m_errout, m_cfg;
  bit          q[$];
  logic [5:0]  m_func, sh_func;
  logic [23:0] m_ins, sh_ins;
  logic [14:0] mg;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_active = 0; m_commit = 0; m_err = 0; m_done = 0; m_errout = 0; m_cfg = 0;
      m_func = '0; m_ins = '0; sh_func = '0; sh_ins = '0;
      q.delete();
      chk_en = 1'b1;
    end else if (m_commit) begin
      m_commit = 0;
      m_done   = 1;
      m_errout = m_err;
      if (!m_err) begin
        m_func = sh_func;
        m_ins  = sh_ins;
        m_cfg  = 1;
      end
    end else begin
      m_done   = 0;
      m_errout = 0;
      if (m_active) begin
        if (bus.ser_valid) begin
          q.push_back(bus.ser_in);
          if (q.size() == BITS) begin
            m_err = 0;
            for (int k = 0; k < N; k++) begin
              for (int j = 0; j < 15; j++) mg[14-j] = q[15*k+j];
              sh_func[3*k +: 3]   = mg[14:12];
              sh_ins[12*k +: 12]  = mg[11:0];
              if (mg[5:0] > 6'd34 || mg[11:6] > 6'd34) m_err = 1;
            end
            m_active = 0;
            m_commit = 1;
          end
        end
      end else if (bus.start) begin
        m_active = 1;
        q.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ser_ready", bus.ser_ready, m_active);
      check("busy", bus.busy, m_active || m_commit);
      check("done", bus.done, m_done);
      check("err", bus.err, m_errout);
      check("cfg_valid", bus.cfg_valid, m_cfg);
      check("conf_func_bus", bus.conf_func_bus, m_func);
      check("conf_ins_bus", bus.conf_ins_bus, m_ins);
    end
  end

  // Called at a negedge; streams the first nbits of the chromosome, MSB first.
  task automatic load(input logic [BITS-1:0] bits, input int duty, input bit poke,
                      input int nbits);
    int   idx = 0;
    int   budget = 0;
    logic rdy;
    t0 = cyc;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1'b1);
    while (idx < nbits && budget < 2000) begin
      bus.ser_valid = ($urandom_range(0, 99) < duty);
      bus.ser_in    = bits[BITS-1-idx];
      bus.start     = poke && (idx == 10);
      rdy           = bus.ser_ready;
      @(posedge clk);
      if (bus.ser_valid && rdy) idx++;
      @(negedge clk);
      budget++;
    end
    bus.ser_valid = 1'b0;
    bus.start     = 1'b0;
    check("bits_sent", idx, nbits);
  endtask

  task automatic wait_done();
    int n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", bus.done, 1'b1);
  endtask

  logic [BITS-1:0] chrom_a, chrom_bad, chrom_b;

  initial begin
    chrom_a   = {gene(3'd3, 6'd5, 6'd34),  gene(3'd2, 6'd0, 6'd0)};
    chrom_bad = {gene(3'd3, 6'd5, 6'd34),  gene(3'd2, 6'd35, 6'd0)};
    chrom_b   = {gene(3'd7, 6'd34, 6'd1),  gene(3'd1, 6'd12, 6'd33)};

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.ser_valid = 1'b0;
    bus.ser_in    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check("rst_func", bus.conf_func_bus, 6'd0);
    check("rst_ins", bus.conf_ins_bus, 24'd0);
    check("rst_cfg_valid", bus.cfg_valid, 1'b0);
    check("rst_done", bus.done, 1'b0);
    repeat (4) begin
      bus.ser_valid = 1'b1;
      bus.ser_in    = 1'b1;
      @(negedge clk);
    end
    bus.ser_valid = 1'b0;
    check("idle_ser_ready", bus.ser_ready, 1'b0);
    check("idle_busy", bus.busy, 1'b0);

    // Nominal load
    load(chrom_a, 100, 1'b0, BITS);
    wait_done();
    check("nom_latency", cyc - t0, 32);
    check("nom_err", bus.err, 1'b0);
    check("nom_func", bus.conf_func_bus, 6'b010_011);
    check("nom_ins", bus.conf_ins_bus, 24'h000_885);
    check("nom_cfg_valid", bus.cfg_valid, 1'b1);
    check("model_func", m_func, 6'b010_011);
    @(negedge clk);
    check("done_one_cycle", bus.done, 1'b0);

    // Out-of-range index is rejected, active buses untouched
    load(chrom_bad, 100, 1'b0, BITS);
    wait_done();
    check("bad_err", bus.err, 1'b1);
    check("bad_func", bus.conf_func_bus, 6'b010_011);
    check("bad_ins", bus.conf_ins_bus, 24'h000_885);
    check("bad_cfg_valid", bus.cfg_valid, 1'b1);
    check("model_err", m_errout, 1'b1);

    // Back-to-back: start issued in the done cycle
    load(chrom_b, 100, 1'b0, BITS);
    wait_done();
    check("b2b_latency", cyc - t0, 32);
    check("b2b_func", bus.conf_func_bus, 6'b001_111);
    check("b2b_ins", bus.conf_ins_bus, 24'h84C_062);
    check("b2b_err", bus.err, 1'b0);

    // Throttled stream with a stray start mid-load
    repeat (2) @(negedge clk);
    load(chrom_a, 30, 1'b1, BITS);
    wait_done();
    check("thr_err", bus.err, 1'b0);
    check("thr_func", bus.conf_func_bus, 6'b010_011);
    check("thr_ins", bus.conf_ins_bus, 24'h000_885);

    // Reset after 20 accepted bits
    repeat (2) @(negedge clk);
    load(chrom_b, 100, 1'b0, 20);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_func", bus.conf_func_bus, 6'd0);
    check("mid_rst_ins", bus.conf_ins_bus, 24'd0);
    check("mid_rst_cfg_valid", bus.cfg_valid, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_ready", bus.ser_ready, 1'b0);
    load(chrom_b, 100, 1'b0, BITS);
    wait_done();
    check("reload_func", bus.conf_func_bus, 6'b001_111);
    check("reload_ins", bus.conf_ins_bus, 24'h84C_062);
    check("reload_cfg_valid", bus.cfg_valid, 1'b1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/chromosome_loader.md
# chromosome_loader

Serial configuration loader for the evolvable logic-element array. It receives a chromosome bit-serially from the genetic-algorithm controller and assembles one 15-bit gene (3-bit function select, two 6-bit input selects) per logic element in a shadow store. After checking every input index against the 35-entry input bus, it atomically commits the whole configuration to the `conf_func`/`conf_ins` buses that drive the logic elements directly downstream.

## Interface
- `N_LE`, default 16: number of logic elements configured; legal range 1..64.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: one-cycle request to begin a load; honoured only in IDLE.
- `ser_in` input 1: chromosome data bit.
- `ser_valid` input 1: `ser_in` is valid this cycle.
- `ser_ready` output 1: loader accepts a bit this cycle. A bit transfers on an edge where `ser_valid && ser_ready`.
- `busy` output 1: high from the cycle after `start` is accepted until commit.
- `done` output 1: one-cycle pulse marking the end of a load.
- `err` output 1: valid with `done`. High means at least one gene held an input index > 34; that load was discarded.
- `cfg_valid` output 1: an error-free configuration has been committed since reset.
- `conf_func_bus` output 3*N_LE: LE k function select in bits [3k+2:3k].
- `conf_ins_bus` output 12*N_LE: LE k input selects in bits [12k+11:12k]. Bits [5:0] are the first operand index and bits [11:6] the second.

## Operation
- FSM states:
  - IDLE: `ser_ready`=0, `busy`=0. `start`=1 moves to SHIFT and clears `bit_cnt`, `le_cnt` and `err_acc`.
  - SHIFT: `ser_ready`=1, `busy`=1. Each accepted bit shifts into a 15-bit gene register, MSB first.
  - COMMIT: a single cycle, then return to IDLE.
- Gene bit order on the wire: func[2], func[1], func[0], ins[11] … ins[0]. LE 0's gene is sent first, LE N_LE-1's last. Total bits = 15*N_LE.
- On acceptance of a gene's 15th bit:
  - write the gene to shadow slot `le_cnt` and increment `le_cnt`;
  - set `err_acc` if ins[5:0] > 34 or ins[11:6] > 34. Both fields are always checked, including for unary functions 2 (NOT) and 7 (BUF).
- After the last gene (`le_cnt` reaches N_LE), move to COMMIT.
- COMMIT with `err_acc`=0: copy all shadow slots to `conf_func_bus`/`conf_ins_bus`, pulse `done`, hold `err`=0, set `cfg_valid`=1.
- COMMIT with `err_acc`=1: leave the active buses and `cfg_valid` unchanged, pulse `done` with `err`=1.
- `start` while not in IDLE is ignored; there is no restart mid-load.
- `ser_valid` outside SHIFT is ignored and no bit is consumed. Gaps in `ser_valid` during SHIFT only stall the load.
- The active buses never change except in COMMIT or on reset, so the logic elements never see a partially written configuration.
- Counters: `bit_cnt` is 4 bits and wraps 14→0 at each gene boundary. `le_cnt` is ceil(log2(N_LE+1)) bits. No arithmetic overflow is possible.

## Timing
- Reset (rst_n=0 at an edge): state IDLE; all counters and the shadow store cleared; `ser_ready`, `busy`, `done`, `err` and `cfg_valid` = 0; `conf_func_bus` and `conf_ins_bus` = 0 (every LE becomes AND of input 0 with itself).
- Reset mid-load discards the partial chromosome and the previously committed configuration.
- `start` sampled high in IDLE at edge T: `busy` and `ser_ready` are high from T+1.
- Last bit accepted at edge E:
  - `ser_ready` is low from E+1 (state COMMIT);
  - at edge E+2, buses and `cfg_valid` update, `done`/`err` go high, and `busy` goes low;
  - `done` is high for exactly cycle E+2..E+3.
- Minimum load time with `ser_valid` held high: 15*N_LE+2 cycles from `start` to `done`.
- `start` asserted in the same cycle that `done` is high is accepted, because the state is IDLE. Back-to-back loads are therefore legal.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset values.** Hold rst_n=0 for 3 cycles, then release. Required: all outputs 0, `ser_ready`=0, and `ser_valid` pulses leave the state unchanged.
- **Nominal load, N_LE=2.** Stream LE0 = func 3, a=5, b=34 (bits 011 100010 000101), then LE1 = func 2, a=0, b=0. Required:
  - `done`=1 and `err`=0 exactly 32 cycles after `start`;
  - `conf_func_bus`=6'b010_011;
  - `conf_ins_bus`=24'h000_885;
  - `cfg_valid`=1.
- **Bad index, N_LE=2.** After the nominal load, stream LE1 with a=35. Required: `done` with `err`=1; buses keep 6'b010_011 / 24'h000_885; `cfg_valid` stays 1.
- **Throttled stream.** Toggle `ser_valid` randomly at about 30% duty and assert `start` again during SHIFT. Required: result identical to the nominal load, and the mid-load `start` has no effect.
- **Reset mid-load.** Assert rst_n=0 after 20 accepted bits. Required: buses = 0, state IDLE; a fresh full load then commits correctly.
- **Back-to-back loads.** Assert `start` in the `done` cycle. Required: `busy`=1 on the next cycle, and the second chromosome commits after another 32 cycles.
